ctrl_decode_stage: RTL and testbench
====================================

CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 7: opcode field width.
REQ-002 SHALL have parameter IMM_SRC_WIDTH, default 3: immediate-format select width, minimum 3.
REQ-003 SHALL have parameter ILL_CNT_WIDTH, default 8: illegal-opcode counter width.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 Ports SHALL be as follows:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  decode stage presents an opcode.
- in_ready  out  1  stage accepts the opcode this cycle.
- op  in  OP_WIDTH  instruction opcode.
- flush  in  1  discard held entry (branch mispredict).
- out_valid  out  1  registered control word valid.
- out_ready  in  1  execute stage consumes the control word.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE  out  1 each  registered controls; ALUSrcAE=1 selects PC as ALU operand A.
- ResultSrcE  out  2  result mux: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
- ALUOpE  out  2  ALU decoder class.
- ImmSrcE  out  IMM_SRC_WIDTH  000 I, 001 S, 010 B, 011 J, 100 U.
- illegal_o  out  1  held entry came from an unimplemented opcode.
- ill_count  out  ILL_CNT_WIDTH  saturating count of accepted illegal opcodes.

Function
REQ-006 SHALL hold one entry in a pipeline register; all E outputs SHALL be registered, with no combinational path from op to them.
REQ-007 SHALL decode as {RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ALUSrcA, ImmSrc, ALUOp}:
- 0000011 lw: 1,01,0,0,0,1,0,000,00
- 0100011 sw: 0,00,1,0,0,1,0,001,00
- 0110011 R-type: 1,00,0,0,0,0,0,000,10
- 0010011 I-ALU: 1,00,0,0,0,1,0,000,10
- 1100011 branch: 0,00,0,0,1,0,0,010,01
- 1101111 jal: 1,10,0,1,0,0,0,011,00
- 1100111 jalr: 1,10,0,1,0,1,0,000,00
- 0110111 lui: 1,11,0,0,0,0,0,100,00
- 0010111 auipc: 1,00,0,0,0,1,1,100,00
REQ-008 Opcode 0 SHALL decode as a bubble: all controls 0, illegal_o=0.
REQ-009 Any other opcode SHALL decode with all controls 0 and illegal_o=1; the stage SHALL never emit X.
REQ-010 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-011 On in_valid && in_ready, the decoded word SHALL be captured and out_valid set 1 at the next edge; accept and consume in the same cycle SHALL give back-to-back throughput at one per cycle, latency 1 cycle.
REQ-012 out_valid && !out_ready SHALL hold all E outputs and illegal_o stable.
REQ-013 On out_ready && out_valid with no new accept, out_valid SHALL go 0 and all controls and illegal_o SHALL go 0.
REQ-014 flush SHALL take priority over accept and hold: at the next edge out_valid=0, all controls 0, illegal_o=0, and op is not captured.
REQ-015 Whenever out_valid=0, all control outputs and illegal_o SHALL be 0.
REQ-016 ill_count SHALL increment by 1 on each accepted illegal opcode, saturating at all-ones; flush SHALL NOT change it, and only rst SHALL clear it.
REQ-017 Widths SHALL follow the parameters; ImmSrc codes SHALL be zero-extended to IMM_SRC_WIDTH.

Reset
REQ-018 rst at an edge SHALL set out_valid=0, all controls 0, illegal_o=0 and ill_count=0, overriding flush and accept in the same cycle.
REQ-019 During rst, in_ready SHALL follow REQ-010 using the reset register values; any opcode accepted during rst SHALL be discarded.
REQ-020 Asserting rst mid-stall SHALL discard the held entry.

Verification
REQ-021 Reset, then lw (0000011) with out_ready=1 -> one cycle later out_valid=1, RegWriteE=1, ResultSrcE=01, ALUSrcE=1, ImmSrcE=000, ALUOpE=00.
REQ-022 Stream lw, sw, R-type, branch, jal, jalr, lui, auipc on consecutive cycles with out_ready=1 -> eight consecutive valid words, each matching the REQ-007 table, with no gaps.
REQ-023 Accept lui, then hold out_ready=0 for 3 cycles while presenting sw -> in_ready=0, lui word held unchanged (ResultSrcE=11, ImmSrcE=100); sw word follows on the cycle after out_ready=1.
REQ-024 Accept op 1111111 -> illegal_o=1, all controls 0, ill_count=1; 300 further illegal accepts with ILL_CNT_WIDTH=8 -> ill_count=255.
REQ-025 flush asserted together with in_valid (beq) while a jal is held -> next cycle out_valid=0, all outputs 0; beq not captured; ill_count unchanged.
REQ-026 rst asserted while a stalled sw is held -> next cycle out_valid=0, MemWriteE=0, ill_count=0.

Source files
------------

// File: rtl/ctrl_decode_stage.sv
// Main-decoder pipeline stage: turns an opcode into a registered
// execute-stage control word behind a one-entry valid/ready register.
module ctrl_decode_stage #(
    parameter int OP_WIDTH      = 7,
    parameter int IMM_SRC_WIDTH = 3,
    parameter int ILL_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_WIDTH-1:0]      op,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     RegWriteE,
    output logic                     MemWriteE,
    output logic                     JumpE,
    output logic                     BranchE,
    output logic                     ALUSrcE,
    output logic                     ALUSrcAE,
    output logic [1:0]               ResultSrcE,
    output logic [1:0]               ALUOpE,
    output logic [IMM_SRC_WIDTH-1:0] ImmSrcE,
    output logic                     illegal_o,
    output logic [ILL_CNT_WIDTH-1:0] ill_count
);

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic       alusrc;
        logic       alusrca;
        logic [2:0] immsrc;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

    localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_R     = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_IALU  = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_BR    = OP_WIDTH'(7'b1100011);
    localparam logic [OP_WIDTH-1:0] OP_JAL   = OP_WIDTH'(7'b1101111);
    localparam logic [OP_WIDTH-1:0] OP_JALR  = OP_WIDTH'(7'b1100111);
    localparam logic [OP_WIDTH-1:0] OP_LUI   = OP_WIDTH'(7'b0110111);
    localparam logic [OP_WIDTH-1:0] OP_AUIPC = OP_WIDTH'(7'b0010111);

    ctrl_t dec;
    ctrl_t q;
    logic  vld;
    logic  accept;

    assign in_ready = (!vld || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    // Opcode zero is a deliberate bubble; every other unknown opcode is illegal.
    always_comb begin
        dec = '0;
        unique case (1'b1)
            op == OP_LW:    dec = 14'b1_01_0_0_0_1_0_000_00_0;
            op == OP_SW:    dec = 14'b0_00_1_0_0_1_0_001_00_0;
            op == OP_R:     dec = 14'b1_00_0_0_0_0_0_000_10_0;
            op == OP_IALU:  dec = 14'b1_00_0_0_0_1_0_000_10_0;
            op == OP_BR:    dec = 14'b0_00_0_0_1_0_0_010_01_0;
            op == OP_JAL:   dec = 14'b1_10_0_1_0_0_0_011_00_0;
            op == OP_JALR:  dec = 14'b1_10_0_1_0_1_0_000_00_0;
            op == OP_LUI:   dec = 14'b1_11_0_0_0_0_0_100_00_0;
            op == OP_AUIPC: dec = 14'b1_00_0_0_0_1_1_100_00_0;
            op == '0:       dec = '0;
            default:        dec.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= 1'b0;
            q         <= '0;
            ill_count <= '0;
        end else if (flush) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (accept) begin
            vld <= 1'b1;
            q   <= dec;
            if (dec.illegal && ill_count != '1)
                ill_count <= ill_count + 1'b1;
        end else if (out_ready) begin
            vld <= 1'b0;
            q   <= '0;
        end
    end

    assign out_valid  = vld;
    assign RegWriteE  = q.regwrite;
    assign ResultSrcE = q.resultsrc;
    assign MemWriteE  = q.memwrite;
    assign JumpE      = q.jump;
    assign BranchE    = q.branch;
    assign ALUSrcE    = q.alusrc;
    assign ALUSrcAE   = q.alusrca;
    assign ImmSrcE    = IMM_SRC_WIDTH'(q.immsrc);
    assign ALUOpE     = q.aluop;
    assign illegal_o  = q.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: decode table stream plus
// stall, flush, illegal-count saturation and reset corner cases.
module tb_ctrl_decode_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] op;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic       RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE;
    logic [1:0] ResultSrcE, ALUOpE;
    logic [2:0] ImmSrcE;
    logic       illegal_o;
    logic [7:0] ill_count;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    ctrl_decode_stage #(
        .OP_WIDTH(7), .IMM_SRC_WIDTH(3), .ILL_CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .ResultSrcE(ResultSrcE),
        .ALUOpE(ALUOpE), .ImmSrcE(ImmSrcE), .illegal_o(illegal_o),
        .ill_count(ill_count)
    );

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[12];

    localparam logic [13:0] W_LW  = 14'b1_01_0_0_0_1_0_000_00_0;
    localparam logic [13:0] W_SW  = 14'b0_00_1_0_0_1_0_001_00_0;
    localparam logic [13:0] W_JAL = 14'b1_10_0_1_0_0_0_011_00_0;
    localparam logic [13:0] W_LUI = 14'b1_11_0_0_0_0_0_100_00_0;
    localparam logic [13:0] W_ILL = 14'b0_00_0_0_0_0_0_000_00_1;

    function automatic logic [13:0] word();
        return {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
                ALUSrcE, ALUSrcAE, ImmSrcE, ALUOpE, illegal_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string name);
        chk({name, ".valid"}, 32'(out_valid), 32'd0);
        chk({name, ".word"}, 32'(word()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_cnt = 0;
    endtask

    initial begin
        tbl[0]  = '{"lw",    7'b0000011, W_LW};
        tbl[1]  = '{"sw",    7'b0100011, W_SW};
        tbl[2]  = '{"rtype", 7'b0110011, 14'b1_00_0_0_0_0_0_000_10_0};
        tbl[3]  = '{"branch",7'b1100011, 14'b0_00_0_0_1_0_0_010_01_0};
        tbl[4]  = '{"jal",   7'b1101111, W_JAL};
        tbl[5]  = '{"jalr",  7'b1100111, 14'b1_10_0_1_0_1_0_000_00_0};
        tbl[6]  = '{"lui",   7'b0110111, W_LUI};
        tbl[7]  = '{"auipc", 7'b0010111, 14'b1_00_0_0_0_1_1_100_00_0};
        tbl[8]  = '{"ialu",  7'b0010011, 14'b1_00_0_0_0_1_0_000_10_0};
        tbl[9]  = '{"bubble",7'b0000000, 14'b0};
        tbl[10] = '{"ill7f", 7'b1111111, W_ILL};
        tbl[11] = '{"ill01", 7'b0000001, W_ILL};

        rst = 1'b1; in_valid = 1'b0; op = '0; flush = 1'b0;
        out_ready = 1'b1;
        do_reset();
        chk_empty("reset");
        chk("reset.cnt", 32'(ill_count), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // Back-to-back stream, one word per cycle, latency 1
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            op = tbl[i].op;
            #1;
            chk({tbl[i].name, ".in_ready"}, 32'(in_ready), 32'd1);
            step();
            if (tbl[i].exp[0]) model_cnt++;
            chk({tbl[i].name, ".valid"}, 32'(out_valid), 32'd1);
            chk({tbl[i].name, ".word"}, 32'(word()), 32'(tbl[i].exp));
            chk({tbl[i].name, ".cnt"}, 32'(ill_count), 32'(model_cnt));
        end
        in_valid = 1'b0;
        step();
        chk_empty("drain");

        // Stall: lui held while sw waits
        in_valid = 1'b1; op = 7'b0110111; out_ready = 1'b1;
        step();
        op = 7'b0100011; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall.in_ready", 32'(in_ready), 32'd0);
            step();
            chk("stall.valid", 32'(out_valid), 32'd1);
            chk("stall.word", 32'(word()), 32'(W_LUI));
        end
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", 32'(in_ready), 32'd1);
        step();
        chk("release.valid", 32'(out_valid), 32'd1);
        chk("release.word", 32'(word()), 32'(W_SW));
        in_valid = 1'b0;
        step();
        chk_empty("release.drain");

        // Flush with a held jal; incoming beq must be dropped
        in_valid = 1'b1; op = 7'b1101111;
        step();
        chk("flush.pre", 32'(word()), 32'(W_JAL));
        out_ready = 1'b0; op = 7'b1100011; flush = 1'b1;
        #1;
        chk("flush.in_ready", 32'(in_ready), 32'd0);
        step();
        chk_empty("flush");
        chk("flush.cnt", 32'(ill_count), 32'(model_cnt));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk_empty("flush.after");

        // Illegal counter saturation
        do_reset();
        in_valid = 1'b1; op = 7'b1111111;
        step();
        chk("ill.word", 32'(word()), 32'(W_ILL));
        chk("ill.cnt1", 32'(ill_count), 32'd1);
        for (int k = 0; k < 300; k++) step();
        chk("ill.sat", 32'(ill_count), 32'd255);
        in_valid = 1'b0;
        step();
        chk("ill.hold", 32'(ill_count), 32'd255);

        // Reset mid-stall discards held sw and clears counter
        in_valid = 1'b1; op = 7'b0100011;
        step();
        out_ready = 1'b0;
        step();
        chk("rststall.pre", 32'(word()), 32'(W_SW));
        op = 7'b0000011; out_ready = 1'b1; rst = 1'b1;
        step();
        chk("rststall.valid", 32'(out_valid), 32'd0);
        chk("rststall.mw", 32'(MemWriteE), 32'd0);
        chk("rststall.word", 32'(word()), 32'd0);
        chk("rststall.cnt", 32'(ill_count), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk_empty("rststall.after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
